// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for a stable lock, then releases
// the system reset. Optional lock-loss statistics are enabled by PLL_LOCK_STATS_EN.
module pll_lock_sequencer #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [7:0] lost_lock_cnt
);

    localparam int unsigned MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned MAX_B = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int unsigned CNT_W = $clog2(MAX_B + 1);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        StPllRst,
        StWaitLock,
        StStable,
        StRun,
        StFail
    } state_t;

    state_t           r_state;
    state_t           w_state_d;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_retry;
    logic [3:0]       w_retry_d;
    logic             r_sync1;
    logic             r_locked_s;
    logic             r_pll_rst;
    logic             r_sys_rst_n;
    logic             r_ready;
    logic             r_fail;
    logic             w_counting;

    always_comb begin
        w_state_d = r_state;
        w_retry_d = r_retry;
        if (restart) begin
            w_state_d = StPllRst;
            w_retry_d = 4'd0;
        end else begin
            unique case (r_state)
                StPllRst: begin
                    if (r_cnt == RST_LAST) w_state_d = StWaitLock;
                end
                StWaitLock: begin
                    if (r_locked_s) begin
                        w_state_d = StStable;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        if (r_retry < RETRY_MAX) begin
                            w_state_d = StPllRst;
                            w_retry_d = r_retry + 4'd1;
                        end else begin
                            w_state_d = StFail;
                        end
                    end
                end
                StStable: begin
                    // A lock glitch only restarts the stability window, not the PLL.
                    if (!r_locked_s) begin
                        w_state_d = StWaitLock;
                    end else if (r_cnt == STABLE_LAST) begin
                        w_state_d = StRun;
                        w_retry_d = 4'd0;
                    end
                end
                StRun: begin
                    if (!r_locked_s) w_state_d = StPllRst;
                end
                StFail: begin
                    w_state_d = StFail;
                end
                default: begin
                    w_state_d = StPllRst;
                end
            endcase
        end
    end

    assign w_counting = (r_state == StPllRst) || (r_state == StWaitLock) ||
                        (r_state == StStable);

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            r_sync1     <= 1'b0;
            r_locked_s  <= 1'b0;
            r_state     <= StPllRst;
            r_cnt       <= '0;
            r_retry     <= 4'd0;
            r_pll_rst   <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_ready     <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_sync1    <= pll_locked;
            r_locked_s <= r_sync1;
            r_state    <= w_state_d;
            r_retry    <= w_retry_d;
            if (restart || (w_state_d != r_state)) begin
                r_cnt <= '0;
            end else if (w_counting) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // Outputs are decoded from the next state so they change with the state register.
            r_pll_rst   <= (w_state_d == StPllRst) || (w_state_d == StFail);
            r_sys_rst_n <= (w_state_d == StRun);
            r_ready     <= (w_state_d == StRun);
            r_fail      <= (w_state_d == StFail);
        end
    end

`ifdef PLL_LOCK_STATS_EN
    logic [7:0] r_lost;
    logic       w_lost;

    assign w_lost = (r_state == StRun) && !r_locked_s && !restart;

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            r_lost <= 8'd0;
        end else if (w_lost && (r_lost != 8'hFF)) begin
            r_lost <= r_lost + 8'd1;
        end
    end

    assign lost_lock_cnt = r_lost;
`else
    assign lost_lock_cnt = 8'd0;
`endif

    assign pll_rst   = r_pll_rst;
    assign sys_rst_n = r_sys_rst_n;
    assign ready     = r_ready;
    assign fail      = r_fail;
    assign retry_cnt = r_retry;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small parameters; expectations are per-edge
// hand-computed cycle numbers counted from the last reset or restart edge.
module tb_pll_lock_sequencer;

    logic       refclk;
    logic       rst_n;
    logic       pll_locked;
    logic       restart;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fail;
    logic [3:0] retry_cnt;
    logic [7:0] lost_lock_cnt;

`ifdef PLL_LOCK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int n;

    pll_lock_sequencer #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (20),
        .STABLE_CYCLES(8),
        .MAX_RETRIES  (2)
    ) dut (
        .refclk       (refclk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .restart      (restart),
        .pll_rst      (pll_rst),
        .sys_rst_n    (sys_rst_n),
        .ready        (ready),
        .fail         (fail),
        .retry_cnt    (retry_cnt),
        .lost_lock_cnt(lost_lock_cnt)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Returns the number of edges until ready rises, or -1 if the bound expires.
    task automatic wait_ready(input int bound, output int cycles);
        cycles = -1;
        for (int i = 1; i <= bound; i++) begin
            tick();
            if (ready === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        pll_locked = 1'b1;
        restart    = 1'b0;
        tick();
        tick();
        chk("rst_pll_rst", 32'(pll_rst), 1);
        chk("rst_sys_rst_n", 32'(sys_rst_n), 0);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_fail", 32'(fail), 0);
        chk("rst_retry", 32'(retry_cnt), 0);
        chk("rst_lost", 32'(lost_lock_cnt), 0);

        // Power-up with lock held: 4-cycle pulse, 2 sync, 1 wait, 8 stable.
        rst_n = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            tick();
            chk("pwr_pll_rst", 32'(pll_rst), 32'(k <= 3));
            chk("pwr_ready", 32'(ready), 32'(k >= 13));
            chk("pwr_sys_rst_n", 32'(sys_rst_n), 32'(k >= 13));
        end
        chk("pwr_retry", 32'(retry_cnt), 0);

        // Lock loss in RUN: reset reaches the outputs on the third edge.
        pll_locked = 1'b0;
        tick();
        chk("loss_e1_sys", 32'(sys_rst_n), 1);
        tick();
        chk("loss_e2_sys", 32'(sys_rst_n), 1);
        tick();
        chk("loss_e3_sys", 32'(sys_rst_n), 0);
        chk("loss_e3_pll", 32'(pll_rst), 1);
        chk("loss_e3_ready", 32'(ready), 0);
        chk("loss_lost1", 32'(lost_lock_cnt), STATS ? 1 : 0);
        pll_locked = 1'b1;
        wait_ready(40, n);
        chk("relock_latency", 32'(n), 13);

        for (int it = 2; it <= 300; it++) begin
            pll_locked = 1'b0;
            tick();
            tick();
            tick();
            chk("loop_sys", 32'(sys_rst_n), 0);
            if (it == 255) chk("loop_lost255", 32'(lost_lock_cnt), STATS ? 255 : 0);
            pll_locked = 1'b1;
            wait_ready(40, n);
            chk("loop_latency", 32'(n), 13);
        end
        chk("lost_sat", 32'(lost_lock_cnt), STATS ? 255 : 0);

        // Reset while in RUN, then no lock at all: two retries and FAIL.
        pll_locked = 1'b0;
        rst_n      = 1'b0;
        tick();
        chk("rrun_pll_rst", 32'(pll_rst), 1);
        chk("rrun_sys", 32'(sys_rst_n), 0);
        chk("rrun_ready", 32'(ready), 0);
        chk("rrun_lost", 32'(lost_lock_cnt), 0);
        rst_n = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            tick();
            chk("to_pll_rst", 32'(pll_rst),
                32'((k <= 3) || (k >= 24 && k <= 27) || (k >= 48 && k <= 51) || (k >= 72)));
            chk("to_retry", 32'(retry_cnt), (k >= 48) ? 2 : ((k >= 24) ? 1 : 0));
            chk("to_fail", 32'(fail), 32'(k >= 72));
            chk("to_sys", 32'(sys_rst_n), 0);
        end

        // Restart out of FAIL.
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("rs_fail", 32'(fail), 0);
        chk("rs_retry", 32'(retry_cnt), 0);
        chk("rs_pll_rst", 32'(pll_rst), 1);
        for (int j = 1; j <= 4; j++) begin
            tick();
            chk("rs_pulse", 32'(pll_rst), 32'(j <= 3));
        end

        // One-cycle lock glitch while the stability counter sits at 5.
        pll_locked = 1'b1;
        for (int w = 1; w <= 18; w++) begin
            tick();
            chk("gl_pll_rst", 32'(pll_rst), 0);
            chk("gl_ready", 32'(ready), 32'(w >= 18));
            if (w == 6) pll_locked = 1'b0;
            if (w == 7) pll_locked = 1'b1;
        end
        chk("gl_retry", 32'(retry_cnt), 0);

        // Restart coinciding with the STABLE->RUN condition.
        restart = 1'b1;
        tick();
        restart = 1'b0;
        for (int j = 1; j <= 12; j++) tick();
        chk("col_pre_sys", 32'(sys_rst_n), 0);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("col_pll_rst", 32'(pll_rst), 1);
        chk("col_sys", 32'(sys_rst_n), 0);
        chk("col_ready", 32'(ready), 0);
        wait_ready(40, n);
        chk("col_latency", 32'(n), 13);
        chk("col_lost", 32'(lost_lock_cnt), 0);

        // Counter survives a restart.
        pll_locked = 1'b0;
        tick();
        tick();
        tick();
        chk("keep_lost1", 32'(lost_lock_cnt), STATS ? 1 : 0);
        pll_locked = 1'b1;
        wait_ready(40, n);
        chk("keep_latency", 32'(n), 13);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("keep_ready", 32'(ready), 0);
        chk("keep_lost_after", 32'(lost_lock_cnt), STATS ? 1 : 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
